// File: rtl/ext_int_conditioner_if.sv
// ext_int_conditioner_if: peripheral bus bundle (addr, w_rb, acc[1:0] with 2=4B access, wdata/rdata 32b, req/resp/fault)
interface ext_int_conditioner_if;
  logic [7:0]  addr;
  logic        w_rb;
  logic [1:0]  acc;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        req;
  logic        resp;
  logic        fault;
  modport master (output addr, w_rb, acc, wdata, req, input rdata, resp, fault);
  modport slave  (input addr, w_rb, acc, wdata, req, output rdata, resp, fault);
endinterface

// File: rtl/ext_int_conditioner.sv
// ext_int_conditioner: polarity/sync/debounce/mask of raw int_pin_i into clean int_out_o levels; EN/POL/DBC/STAT regs on bus slave
module ext_int_conditioner #(
  parameter int          SRC_NUM     = 4,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] DBC_RST     = 16'h000F
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SRC_NUM-1:0] int_pin_i,
  output logic [SRC_NUM-1:0] int_out_o,
  ext_int_conditioner_if.slave bus
);
  logic [SRC_NUM-1:0]                  en_q, pol_q, stable_q, stable_d, s;
  logic [15:0]                         dbc_q;
  logic [SYNC_STAGES-1:0][SRC_NUM-1:0] sync_q;
  logic [SRC_NUM-1:0][15:0]            cnt_q, cnt_d;
  logic [31:0]                         rdata_q, rdata_d;
  logic                                resp_q, invld, valid, wr, rd;
  logic [1:0]                          sel;
  logic                                unused;
  assign unused = ^bus.wdata[31:16];
  assign sel    = bus.addr[3:2];
  // 4B-only, word-aligned, 0x0..0xC, and STAT is read-only
  assign invld  = (bus.acc != 2'd2) | (bus.addr[1:0] != 2'd0) | (bus.addr[7:4] != 4'd0) | (bus.w_rb & (sel == 2'd3));
  assign valid  = bus.req & ~invld;
  assign wr     = valid & bus.w_rb;
  assign rd     = valid & ~bus.w_rb;
  assign bus.fault = bus.req & invld;
  assign bus.resp  = resp_q;
  assign bus.rdata = rdata_q;
  assign s         = sync_q[SYNC_STAGES-1];
  assign int_out_o = stable_q & en_q;
  assign rdata_d = sel == 2'd0 ? 32'(en_q) : sel == 2'd1 ? 32'(pol_q) : sel == 2'd2 ? 32'(dbc_q) : 32'(stable_q);
  for (genvar i = 0; i < SRC_NUM; i++) begin : g_src
    // a change commits only after it has been seen on D+1 consecutive cycles
    assign stable_d[i] = (s[i] != stable_q[i] && cnt_q[i] >= dbc_q) ? s[i] : stable_q[i];
    assign cnt_d[i]    = (s[i] == stable_q[i] || cnt_q[i] >= dbc_q) ? 16'd0 : cnt_q[i] + 16'd1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= '0;
      pol_q    <= '0;
      dbc_q    <= DBC_RST;
      sync_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      resp_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], int_pin_i ^ pol_q};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      resp_q   <= valid;
      if (wr && sel == 2'd0) en_q  <= bus.wdata[SRC_NUM-1:0];
      if (wr && sel == 2'd1) pol_q <= bus.wdata[SRC_NUM-1:0];
      if (wr && sel == 2'd2) dbc_q <= bus.wdata[15:0];
      if (rd) rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_ext_int_conditioner.sv
// tb_ext_int_conditioner: directed self-checking bench for ext_int_conditioner
module tb_ext_int_conditioner;
  logic       clk;
  logic       rst;
  logic [3:0] int_pin;
  logic [3:0] int_out;
  int         n_cmp = 0;
  int         n_bad = 0;
  ext_int_conditioner_if bus_if();
  ext_int_conditioner #(.SRC_NUM(4), .SYNC_STAGES(2), .DBC_RST(16'h000F)) dut (
    .clk(clk), .rst(rst), .int_pin_i(int_pin), .int_out_o(int_out), .bus(bus_if)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic bus_acc(input logic w, input logic [7:0] a, input logic [1:0] ac, input logic [31:0] wd,
                         output logic f, output logic r, output logic [31:0] rd);
    @(negedge clk);
    bus_if.req = 1'b1; bus_if.w_rb = w; bus_if.addr = a; bus_if.acc = ac; bus_if.wdata = wd;
    #1 f = bus_if.fault;
    @(negedge clk);
    r = bus_if.resp; rd = bus_if.rdata;
    bus_if.req = 1'b0;
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic test_reset();
    logic f, r; logic [31:0] rd;
    rst = 1'b1; int_pin = '0;
    bus_if.req = 1'b0; bus_if.w_rb = 1'b0; bus_if.addr = '0; bus_if.acc = 2'd2; bus_if.wdata = '0;
    wait_cyc(2);
    n_cmp++; if (int_out !== 4'h0) begin n_bad++; $display("FAIL rst_int_out got %h exp 0", int_out); end
    n_cmp++; if (bus_if.resp !== 1'b0) begin n_bad++; $display("FAIL rst_resp got %b exp 0", bus_if.resp); end
    n_cmp++; if (bus_if.rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got %h exp 0", bus_if.rdata); end
    rst = 1'b0;
    wait_cyc(1);
    bus_acc(1'b0, 8'h8, 2'd2, 32'h0, f, r, rd);
    n_cmp++; if (rd !== 32'h000F) begin n_bad++; $display("FAIL rst_dbc got %h exp 0000000f", rd); end
    n_cmp++; if (r !== 1'b1 || f !== 1'b0) begin n_bad++; $display("FAIL rst_rd_resp got r=%b f=%b exp r=1 f=0", r, f); end
    bus_acc(1'b0, 8'h0, 2'd2, 32'h0, f, r, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rst_en got %h exp 0", rd); end
    bus_acc(1'b0, 8'h4, 2'd2, 32'h0, f, r, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rst_pol got %h exp 0", rd); end
    bus_acc(1'b0, 8'hC, 2'd2, 32'h0, f, r, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rst_stat got %h exp 0", rd); end
  endtask
  task automatic test_latency();
    logic f, r; logic [31:0] rd;
    bus_acc(1'b1, 8'h0, 2'd2, 32'h1, f, r, rd);
    n_cmp++; if (r !== 1'b1) begin n_bad++; $display("FAIL wr_resp got %b exp 1", r); end
    bus_acc(1'b1, 8'h8, 2'd2, 32'h3, f, r, rd);
    wait_cyc(4);
    int_pin[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (int_out[0] !== (k >= 6)) begin n_bad++; $display("FAIL latency_k%0d got %b exp %b", k, int_out[0], k >= 6); end
    end
    bus_acc(1'b0, 8'hC, 2'd2, 32'h0, f, r, rd);
    n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL latency_stat got %h exp 1", rd); end
    int_pin[0] = 1'b0;
    wait_cyc(10);
    n_cmp++; if (int_out !== 4'h0) begin n_bad++; $display("FAIL latency_fall got %h exp 0", int_out); end
  endtask
  task automatic test_glitch();
    logic f, r; logic [31:0] rd; int hi;
    hi = 0;
    int_pin[0] = 1'b1;
    wait_cyc(3);
    int_pin[0] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (int_out[0]) hi++;
    end
    n_cmp++; if (hi !== 0) begin n_bad++; $display("FAIL glitch_out high_cycles %0d exp 0", hi); end
    bus_acc(1'b0, 8'hC, 2'd2, 32'h0, f, r, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL glitch_stat got %h exp 0", rd); end
  endtask
  task automatic test_polarity();
    logic f, r; logic [31:0] rd;
    bus_acc(1'b1, 8'h4, 2'd2, 32'h2, f, r, rd);
    bus_acc(1'b1, 8'h0, 2'd2, 32'h3, f, r, rd);
    wait_cyc(8);
    n_cmp++; if (int_out !== 4'h2) begin n_bad++; $display("FAIL pol_rise got %h exp 2", int_out); end
    int_pin[1] = 1'b1;
    wait_cyc(5);
    n_cmp++; if (int_out[1] !== 1'b1) begin n_bad++; $display("FAIL pol_hold got %b exp 1", int_out[1]); end
    wait_cyc(1);
    n_cmp++; if (int_out[1] !== 1'b0) begin n_bad++; $display("FAIL pol_fall got %b exp 0", int_out[1]); end
    int_pin[1] = 1'b0;
    wait_cyc(8);
    bus_acc(1'b1, 8'h0, 2'd2, 32'h1, f, r, rd);
    n_cmp++; if (int_out !== 4'h0) begin n_bad++; $display("FAIL en_mask got %h exp 0", int_out); end
    bus_acc(1'b0, 8'hC, 2'd2, 32'h0, f, r, rd);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL en_mask_stat got %h exp 2", rd); end
  endtask
  task automatic test_fault();
    logic f, r; logic [31:0] rd;
    bus_acc(1'b1, 8'hC, 2'd2, 32'hF, f, r, rd);
    n_cmp++; if (f !== 1'b1 || r !== 1'b0) begin n_bad++; $display("FAIL fault_stat_wr got f=%b r=%b exp f=1 r=0", f, r); end
    bus_acc(1'b1, 8'h0, 2'd1, 32'hF, f, r, rd);
    n_cmp++; if (f !== 1'b1 || r !== 1'b0) begin n_bad++; $display("FAIL fault_2b got f=%b r=%b exp f=1 r=0", f, r); end
    bus_acc(1'b1, 8'h10, 2'd2, 32'h0, f, r, rd);
    n_cmp++; if (f !== 1'b1 || r !== 1'b0) begin n_bad++; $display("FAIL fault_0x10 got f=%b r=%b exp f=1 r=0", f, r); end
    bus_acc(1'b1, 8'h6, 2'd2, 32'h0, f, r, rd);
    n_cmp++; if (f !== 1'b1 || r !== 1'b0) begin n_bad++; $display("FAIL fault_misalign got f=%b r=%b exp f=1 r=0", f, r); end
    bus_acc(1'b0, 8'h0, 2'd2, 32'h0, f, r, rd);
    n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL fault_en_kept got %h exp 1", rd); end
    bus_acc(1'b0, 8'h4, 2'd2, 32'h0, f, r, rd);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL fault_pol_kept got %h exp 2", rd); end
    bus_acc(1'b0, 8'h8, 2'd2, 32'h0, f, r, rd);
    n_cmp++; if (rd !== 32'h3) begin n_bad++; $display("FAIL fault_dbc_kept got %h exp 3", rd); end
    bus_acc(1'b0, 8'h9, 2'd2, 32'h0, f, r, rd);
    n_cmp++; if (rd !== 32'h3 || r !== 1'b0) begin n_bad++; $display("FAIL fault_rd_hold got rd=%h r=%b exp rd=3 r=0", rd, r); end
  endtask
  task automatic test_d0_toggle();
    logic f, r; logic [31:0] rd; logic pat [12];
    bus_acc(1'b1, 8'h4, 2'd2, 32'h0, f, r, rd);
    bus_acc(1'b1, 8'h8, 2'd2, 32'h0, f, r, rd);
    bus_acc(1'b1, 8'h0, 2'd2, 32'h1, f, r, rd);
    wait_cyc(6);
    for (int t = 0; t < 12; t++) pat[t] = t[0];
    for (int t = 0; t < 12; t++) begin
      int_pin[0] = pat[t];
      @(negedge clk);
      if (t >= 2) begin
        n_cmp++;
        if (int_out[0] !== pat[t-2]) begin n_bad++; $display("FAIL d0_t%0d got %b exp %b", t, int_out[0], pat[t-2]); end
      end
    end
    int_pin[0] = 1'b1;
    wait_cyc(4);
    n_cmp++; if (int_out !== 4'h1) begin n_bad++; $display("FAIL d0_pre_rst got %h exp 1", int_out); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (int_out !== 4'h0) begin n_bad++; $display("FAIL async_rst_out got %h exp 0", int_out); end
    wait_cyc(1);
    rst = 1'b0;
    bus_acc(1'b0, 8'h8, 2'd2, 32'h0, f, r, rd);
    n_cmp++; if (rd !== 32'h000F) begin n_bad++; $display("FAIL async_rst_dbc got %h exp f", rd); end
    bus_acc(1'b0, 8'h0, 2'd2, 32'h0, f, r, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL async_rst_en got %h exp 0", rd); end
  endtask
  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_polarity();
    test_fault();
    test_d0_toggle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
